// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: redirect input, instruction-memory port and IF/ID output slot.
// master = fetch_sequencer side, slave = surrounding pipeline / memory side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
);
  logic              jump_enable;
  logic [ADDR_W-1:0] jump_address;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [INSN_W-1:0] imem_rdata;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INSN_W-1:0] if_insn;
  logic              id_ready;
  logic              fetch_fault;

  modport master (
    input  jump_enable, jump_address, imem_valid, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_insn, fetch_fault
  );

  modport slave (
    output jump_enable, jump_address, imem_valid, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_insn, fetch_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC selection, single outstanding imem request, squash on redirect.
// Optional macro FETCH_MISALIGN_CHECK_EN rejects redirects to non-word-aligned targets.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
  logic [INSN_W-1:0] slot_insn_q, slot_insn_d;

  logic issue_s;
  logic load_s;
  logic misalign_s;
  logic halt_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_q, halt_d;
  logic fault_q, fault_d;

  // A rejected redirect parks fetch until the next aligned redirect arrives.
  always_comb begin
    misalign_s = bus.jump_enable && (bus.jump_address[1:0] != 2'b00);
    fault_d    = misalign_s;
    if (bus.jump_enable) begin
      halt_d = misalign_s;
    end else begin
      halt_d = halt_q;
    end
  end

  // Halt flag and one-cycle fault pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      halt_q  <= halt_d;
      fault_q <= fault_d;
    end
  end

  assign halt_s          = halt_q;
  assign bus.fetch_fault = fault_q;
`else
  assign misalign_s      = 1'b0;
  assign halt_s          = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  // Issue is gated by reset so no strobe escapes while the block is held in reset.
  assign issue_s = rst && (state_q == S_IDLE) && !bus.jump_enable && !halt_s &&
                   (!slot_valid_q || bus.id_ready);
  assign load_s  = (state_q == S_WAIT) && bus.imem_valid && !bus.jump_enable;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.imem_valid) begin
          state_d = S_IDLE;
        end else if (bus.jump_enable) begin
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (bus.imem_valid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs: request strobe and address
  always_comb begin
    bus.imem_req  = issue_s;
    bus.imem_addr = pc_q;
  end

  // PC, request-address and output-slot next-state logic
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    slot_insn_d  = slot_insn_q;

    if (bus.jump_enable) begin
      if (!misalign_s) begin
        pc_d = bus.jump_address;
      end else begin
        pc_d = pc_q;
      end
    end else if (load_s) begin
      pc_d = req_pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end

    if (issue_s) begin
      req_pc_d = pc_q;
    end else begin
      req_pc_d = req_pc_q;
    end

    // Redirect flushes the slot even when decode is stalled.
    if (bus.jump_enable) begin
      slot_valid_d = 1'b0;
    end else if (load_s) begin
      slot_valid_d = 1'b1;
      slot_pc_d    = req_pc_q;
      slot_insn_d  = bus.imem_rdata;
    end else if (slot_valid_q && bus.id_ready) begin
      slot_valid_d = 1'b0;
    end else begin
      slot_valid_d = slot_valid_q;
    end
  end

  // PC, request-address and output-slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= {ADDR_W{1'b0}};
      slot_valid_q <= 1'b0;
      slot_pc_q    <= {ADDR_W{1'b0}};
      slot_insn_q  <= {INSN_W{1'b0}};
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_insn_q  <= slot_insn_d;
    end
  end

  assign bus.if_valid = slot_valid_q;
  assign bus.if_pc    = slot_pc_q;
  assign bus.if_insn  = slot_insn_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small latency-programmable imem responder.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nasserts = 0;
  int   nfails   = 0;

  int          lat   = 1;
  logic        pend  = 1'b0;
  int          cnt   = 0;
  logic [31:0] paddr = 32'h0;

  fetch_sequencer_if #(.ADDR_W(32), .INSN_W(32)) bus ();

  fetch_sequencer #(
    .ADDR_W  (32),
    .INSN_W  (32),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    nasserts++;
    assert (got === exp) else begin
      nfails++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nasserts++;
    assert (got === exp) else begin
      nfails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the responder answers a request seen in cycle t at cycle t+lat.
  task automatic tick();
    logic        rs;
    logic [31:0] ra;
    @(negedge clk);
    rs = bus.imem_req;
    ra = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_valid = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem(paddr);
        pend = 1'b0;
      end
    end
    if (rs) begin
      paddr = ra;
      cnt   = lat - 1;
      if (cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem(ra);
      end else begin
        pend = 1'b1;
      end
    end
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] pc);
    chk1 ({tag, "_valid"}, bus.if_valid, 1'b1);
    chk32({tag, "_pc"},    bus.if_pc,    pc);
    chk32({tag, "_insn"},  bus.if_insn,  mem(pc));
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk1(tag, bus.imem_req, req);
    if (req) begin
      chk32({tag, "_addr"}, bus.imem_addr, addr);
    end
  endtask

  initial begin
    bus.jump_enable  = 1'b0;
    bus.jump_address = 32'h0;
    bus.imem_valid   = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.id_ready     = 1'b1;

    tick();
    tick();
    chk1 ("rst_if_valid", bus.if_valid,    1'b0);
    chk32("rst_if_pc",    bus.if_pc,       32'h0);
    chk32("rst_if_insn",  bus.if_insn,     32'h0);
    chk1 ("rst_fault",    bus.fetch_fault, 1'b0);
    chk1 ("rst_req",      bus.imem_req,    1'b0);

    // Sequential fetch, L=1, decode always ready
    rst = 1'b1;
    #1;
    chk_req("seq_req0", 1'b1, 32'h100);
    tick();
    chk_req("seq_wait0", 1'b0, 32'h0);
    chk1("seq_empty0", bus.if_valid, 1'b0);
    tick();
    chk_slot("seq_slot0", 32'h100);
    chk_req("seq_req1", 1'b1, 32'h104);
    tick();
    chk1("seq_empty1", bus.if_valid, 1'b0);
    chk_req("seq_wait1", 1'b0, 32'h0);
    tick();
    chk_slot("seq_slot1", 32'h104);

    // Backpressure: slot full, decode stalled
    bus.id_ready = 1'b0;
    #1;
    chk_req("bp_noreq", 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_slot("bp_hold", 32'h104);
      chk_req("bp_noreq_loop", 1'b0, 32'h0);
    end
    bus.id_ready = 1'b1;
    #1;
    chk_req("bp_release_req", 1'b1, 32'h108);
    chk_slot("bp_release_slot", 32'h104);

    // L=4, redirect two cycles after the 0x108 request
    lat = 4;
    tick();
    chk1("jw_empty", bus.if_valid, 1'b0);
    chk_req("jw_wait", 1'b0, 32'h0);
    tick();
    bus.jump_enable  = 1'b1;
    bus.jump_address = 32'h400;
    #1;
    chk_req("jw_jump_noreq", 1'b0, 32'h0);
    tick();
    bus.jump_enable = 1'b0;
    #1;
    chk_req("jw_drop_noreq0", 1'b0, 32'h0);
    chk1("jw_drop_empty0", bus.if_valid, 1'b0);
    tick();
    chk_req("jw_drop_noreq1", 1'b0, 32'h0);
    chk1("jw_drop_empty1", bus.if_valid, 1'b0);
    lat = 1;
    tick();
    chk1("jw_discarded", bus.if_valid, 1'b0);
    chk_req("jw_target_req", 1'b1, 32'h400);
    tick();
    tick();
    chk_slot("jw_target_slot", 32'h400);
    chk_req("jw_next_req", 1'b1, 32'h404);

    // Redirect coinciding with the response
    tick();
    bus.jump_enable  = 1'b1;
    bus.jump_address = 32'h200;
    #1;
    chk_req("jv_noreq", 1'b0, 32'h0);
    tick();
    bus.jump_enable = 1'b0;
    #1;
    chk1("jv_discard", bus.if_valid, 1'b0);
    chk_req("jv_target_req", 1'b1, 32'h200);
    tick();
    tick();
    chk_slot("jv_target_slot", 32'h200);

    // Redirect flushes a stalled full slot
    bus.id_ready     = 1'b0;
    bus.jump_enable  = 1'b1;
    bus.jump_address = 32'h300;
    #1;
    chk_req("js_noreq", 1'b0, 32'h0);
    tick();
    bus.jump_enable = 1'b0;
    bus.id_ready    = 1'b1;
    #1;
    chk1("js_flushed", bus.if_valid, 1'b0);
    chk_req("js_target_req", 1'b1, 32'h300);
    tick();
    tick();
    chk_slot("js_target_slot", 32'h300);
    chk_req("js_next_req", 1'b1, 32'h304);

    // Async reset while WAIT; stale response lands in the release cycle
    lat = 4;
    tick();
    rst = 1'b0;
    #1;
    chk1 ("ar_if_valid", bus.if_valid, 1'b0);
    chk32("ar_if_pc",    bus.if_pc,    32'h0);
    chk1 ("ar_req",      bus.imem_req, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    lat = 1;
    #1;
    chk_req("ar_first_req", 1'b1, 32'h100);
    tick();
    chk1("ar_stale_ignored", bus.if_valid, 1'b0);
    tick();
    chk_slot("ar_slot", 32'h100);
    chk_req("ar_next_req", 1'b1, 32'h104);
    tick();
    tick();
    chk_slot("ar_slot1", 32'h104);

    // Redirect to a non-word-aligned target
    bus.jump_enable  = 1'b1;
    bus.jump_address = 32'h402;
    #1;
    chk_req("mis_noreq", 1'b0, 32'h0);
    tick();
    bus.jump_enable = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk1("mis_fault_pulse", bus.fetch_fault, 1'b1);
    chk1("mis_flushed", bus.if_valid, 1'b0);
    chk_req("mis_halt0", 1'b0, 32'h0);
    tick();
    chk1("mis_fault_end", bus.fetch_fault, 1'b0);
    chk_req("mis_halt1", 1'b0, 32'h0);
    tick();
    chk_req("mis_halt2", 1'b0, 32'h0);
    bus.jump_enable  = 1'b1;
    bus.jump_address = 32'h500;
    #1;
    chk_req("mis_resume_noreq", 1'b0, 32'h0);
    tick();
    bus.jump_enable = 1'b0;
    #1;
    chk1("mis_resume_fault", bus.fetch_fault, 1'b0);
    chk_req("mis_resume_req", 1'b1, 32'h500);
    tick();
    tick();
    chk_slot("mis_resume_slot", 32'h500);
`else
    chk1("mis_no_fault", bus.fetch_fault, 1'b0);
    chk1("mis_flushed", bus.if_valid, 1'b0);
    chk_req("mis_verbatim_req", 1'b1, 32'h402);
    tick();
    tick();
    chk_slot("mis_verbatim_slot", 32'h402);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that sequences the program counter and the instruction-memory port, and presents fetched instructions to decode through a single-entry output register with valid/ready backpressure. It decides the next PC from three sources: reset vector, sequential (+4) and jump redirect. It keeps at most one memory request outstanding and squashes in-flight fetches on redirect. It sits between the hazard/branch logic and the instruction memory, in front of the IF/ID boundary.

## Interface
- `ADDR_W`, 32, PC and memory address width
- `INSN_W`, 32, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `jump_enable`  in  1  redirect request, single-cycle qualifier
- `jump_address`  in  ADDR_W  redirect target
- `imem_req`  out  1  request strobe, one cycle per request
- `imem_addr`  out  ADDR_W  request address, valid when `imem_req`=1
- `imem_valid`  in  1  response strobe, ≥1 cycle after request
- `imem_rdata`  in  INSN_W  response data, valid with `imem_valid`
- `if_valid`  out  1  output slot holds an instruction
- `if_pc`  out  ADDR_W  PC of held instruction
- `if_insn`  out  INSN_W  held instruction
- `id_ready`  in  1  decode accepts slot this cycle
- `fetch_fault`  out  1  misaligned-redirect pulse (see Configuration)

## Operation
- States: IDLE (nothing outstanding), WAIT (one live request outstanding), DROP (one squashed request outstanding).
- `pc` register holds the address of the next request. `req_pc` holds the address of the outstanding request.
- Issue condition (combinational `imem_req`): state IDLE, no `jump_enable` this cycle, and slot free at next edge (`!if_valid || id_ready`). On issue: `imem_addr`=`pc`, `req_pc`<=`pc`, go to WAIT.
- WAIT and `imem_valid`: slot <= {1, `req_pc`, `imem_rdata`}, `pc` <= `req_pc`+4 (mod 2^ADDR_W), go to IDLE.
- DROP and `imem_valid`: data discarded, go to IDLE.
- IDLE and `imem_valid`: ignored (stale response after reset).
- Redirect (`jump_enable`=1) has priority over everything:
  - `pc` <= `jump_address`.
  - Slot cleared (`if_valid`<=0) regardless of `id_ready`.
  - WAIT without `imem_valid` goes to DROP.
  - WAIT with `imem_valid` in the same cycle discards the data and goes to IDLE.
  - DROP stays DROP. IDLE stays IDLE.
  - No request is issued in the redirect cycle.
- Slot consumption: `if_valid && id_ready` and no load this cycle clears `if_valid`. With `id_ready`=0, `if_valid`, `if_pc` and `if_insn` hold stable.

## Timing
- Reset values:
  - `pc`=RESET_PC, state IDLE.
  - `if_valid`=0, `if_pc`=0, `if_insn`=0, `fetch_fault`=0.
  - `imem_req`=0 while `rst`=0.
- First request is issued in the first cycle after `rst` deasserts, at RESET_PC.
- Latency: a request at cycle t with response at t+L gives `if_valid`=1 from t+L+1.
- Throughput with L=1 and `id_ready`=1: one instruction every 2 cycles.
- Redirect at cycle t gives the first request to `jump_address` at t+1 if IDLE. If DROP, it waits until the squashed response arrives, then issues next cycle.
- Async reset mid-request aborts it. A late `imem_valid` is absorbed in IDLE.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `jump_address[1:0]`≠0 is rejected.
  - `pc` is unchanged.
  - Slot and in-flight request are still flushed, exactly as for a normal redirect.
  - `fetch_fault`=1 for exactly one cycle (t+1).
  - Fetch halts in IDLE, with no issue, until the next aligned redirect.
- Undefined: no check. `fetch_fault` is tied 0 and targets are used verbatim.

## Test plan
- Reset with RESET_PC=0x100, memory L=1, `id_ready`=1 -> requests at 0x100, 0x104, 0x108 every 2 cycles; `if_pc` sequence matches, `if_insn` equals the returned data.
- Hold `id_ready`=0 for 5 cycles with slot full -> `if_*` stable, no `imem_req`; release -> next request issues in the release cycle.
- Memory L=4, `jump_enable` to 0x400 two cycles after request to 0x108 -> response for 0x108 dropped, never visible; next request is 0x400, `if_pc`=0x400.
- `jump_enable` in the same cycle as `imem_valid` -> data discarded, `if_valid` stays 0, next request at target.
- Assert `rst` while in WAIT, release, return stale `imem_valid` -> ignored; first request at RESET_PC.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x402 -> `fetch_fault` one-cycle pulse, no requests; redirect to 0x500 -> fetch resumes at 0x500.
